mem_req_queue: RTL
==================

# mem_req_queue

Load/store request queue between the execute stage and `dmem`. It accepts memory instructions from execute through a valid/ready handshake and buffers up to `DEPTH` requests. Requests are issued in order, one per cycle, onto the `dmem` `en/instr/addr/di` inputs. One cycle after each issue, the block captures `dmem`'s registered `dout/err` and presents the result to writeback, tagged with the destination register. A misaligned access halts further issue until flush.

## Interface
- `DEPTH`, 4: queue entries; power of 2, ≥2.
- `TAG_W`, 5: destination register tag width.

- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous queue/response clear.
- `in_valid` in 1: execute presents a request.
- `in_ready` out 1: queue can accept the request.
- `in_instr` in 32: instruction word; bits [6:0] and [14:12] are used downstream.
- `in_addr` in 32: effective address.
- `in_data` in 32: store data (rs2).
- `in_rd` in TAG_W: destination register.
- `mem_en` out 1: to `dmem` en; high only on the issue cycle.
- `mem_instr` out 32: to `dmem` instr; 32'h00000013 (NOP) when not issuing.
- `mem_addr` out 32: to `dmem` addr; 0 when not issuing.
- `mem_di` out 32: to `dmem` di; 0 when not issuing.
- `mem_dout` in 32: from `dmem`, registered read data.
- `mem_err` in 1: from `dmem`, registered misalignment flag.
- `out_valid` out 1: result pulse to writeback.
- `out_is_load` out 1: result is a load; writeback must write `out_rd`.
- `out_rd` out TAG_W: tag of the result.
- `out_data` out 32: equals `mem_dout`; don't-care when `out_is_load`=0.
- `out_err` out 1: access faulted; qualified by `out_valid`.
- `halted` out 1: sticky fault halt.

## Operation
- Acceptance filter:
  - A request is accepted when `in_valid & in_ready`.
  - Opcode 7'b0000011 (load) or 7'b0100011 (store) is enqueued.
  - Any other opcode is consumed and dropped; no entry is created.
- Each entry holds `{instr, addr, data, rd, is_load}`.
- The circular FIFO uses `log2(DEPTH)`-bit read/write pointers plus a `count` of width `log2(DEPTH)+1`. Pointers wrap modulo `DEPTH`.
- `in_ready = !rst & !flush & (count < DEPTH)`. There is no pass-through when full, even if an issue happens in the same cycle.
- Issue condition: `issue = (count>0) & !halted & !(resp_valid & mem_err) & !flush & !rst`.
  - On issue, the head entry drives `mem_*` combinationally and `mem_en`=1.
  - The head is popped at the clock edge.
- Response register:
  - `resp_valid <= issue`.
  - `resp_rd`/`resp_is_load` are captured from the issued entry.
  - `out_valid = resp_valid`. `out_data`/`out_err` are taken directly from `mem_dout`/`mem_err`.
- Fault:
  - `out_valid & mem_err` sets `halted` at the next edge.
  - The fault also blocks issue combinationally in the same cycle, so no younger request ever reaches `dmem`.
  - `halted` holds until `flush` or `rst`. Queued entries are retained while halted, and acceptance continues until full.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Flush:
  - Clears pointers, `count`, `resp_valid` and `halted` at the edge.
  - Flush wins over any push or issue in that cycle; `in_valid` is ignored.
- Reset has the same effect as flush, plus all outputs go to their reset values. An in-flight response is discarded, and `out_valid`=0 in the cycle after reset.
- Reset values:
  - `in_ready`=0 during reset, 1 afterwards.
  - `mem_en`=0, `mem_instr`=32'h13, `mem_addr`=0, `mem_di`=0.
  - `out_valid`=0, `out_is_load`=0, `out_rd`=0, `out_err`=0, `halted`=0.

## Timing
- Baseline (no bypass):
  - Accept at cycle N; entry is visible at N+1.
  - Earliest issue at N+1 (`mem_en`=1); `out_valid` at N+2.
  - Load-to-writeback latency is 2 cycles.
- Throughput: 1 request per cycle sustained in both directions.
- With a full queue and issue each cycle, `in_ready` stays 0 for that cycle and rises the cycle after the pop.
- `out_valid` is never back-pressured; writeback must accept every pulse.

## Configuration
- `MEM_REQ_QUEUE_BYPASS_EN`:
  - When defined: if `count==0`, the accepted request is a load/store, and no halt/flush/fault blocks issue, the request drives `mem_*` combinationally in its accept cycle and is not written to the FIFO. Latency is 1 cycle (accept N, `out_valid` N+1).
  - When undefined: the bypass path is absent and latency is 2 cycles as above.

## Test plan
- LW x5 at addr 0x100 after an SW of 0xDEADBEEF to 0x100, back-to-back:
  - `mem_en` high for two consecutive cycles.
  - Second `out_valid` has `out_is_load`=1, `out_rd`=5, `out_data`=0xDEADBEEF.
  - Latency is 2 cycles (1 with `MEM_REQ_QUEUE_BYPASS_EN`).
- Fill with 4 LBU requests while issue is blocked (halted) → `in_ready`=0 after the 4th; a 5th request with `in_valid` held stays pending; `count`=4.
- LW to 0x102 followed by LW to 0x104:
  - `out_err`=1 on the first result; `halted`=1 next cycle.
  - The second request is never issued (`mem_en`=0) until `flush`.
  - After `flush`, `count`=0 and `halted`=0.
- ADDI (opcode 0010011) with `in_valid`=1 → accepted (`in_ready`=1), `count` stays 0, no `mem_en`, no `out_valid`.
- `rst` asserted the cycle after an LW issue → `out_valid`=0 the following cycle, `in_ready`=0 during reset, and all outputs hold their reset values.
- Continuous push+issue with `count`=1 for 8 cycles → `count` stays 1, pointers wrap past `DEPTH`-1 to 0, and results return in order with correct `out_rd` tags.

Source files
------------

// File: rtl/mem_req_queue_if.sv
// mem_req_queue_if: bundles the signals between mem_req_queue and its neighbours.
//   Request channel (execute -> queue): in_valid/in_ready handshake, in_instr, in_addr,
//                                       in_data, in_rd
//   dmem channel (queue <-> dmem):      mem_en, mem_instr, mem_addr, mem_di out,
//                                       mem_dout, mem_err back (registered inside dmem)
//   Result channel (queue -> writeback): out_valid, out_is_load, out_rd, out_data, out_err
//   Control/status:                     flush in, halted out
// The slave modport is the queue's view; master is the surrounding pipeline's view.
interface mem_req_queue_if #(
  parameter int unsigned TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_addr;
  logic [31:0]      in_data;
  logic [TAG_W-1:0] in_rd;
  logic             mem_en;
  logic [31:0]      mem_instr;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_di;
  logic [31:0]      mem_dout;
  logic             mem_err;
  logic             out_valid;
  logic             out_is_load;
  logic [TAG_W-1:0] out_rd;
  logic [31:0]      out_data;
  logic             out_err;
  logic             halted;

  modport slave (
    input  flush, in_valid, in_instr, in_addr, in_data, in_rd, mem_dout, mem_err,
    output in_ready, mem_en, mem_instr, mem_addr, mem_di,
           out_valid, out_is_load, out_rd, out_data, out_err, halted
  );

  modport master (
    output flush, in_valid, in_instr, in_addr, in_data, in_rd, mem_dout, mem_err,
    input  in_ready, mem_en, mem_instr, mem_addr, mem_di,
           out_valid, out_is_load, out_rd, out_data, out_err, halted
  );
endinterface

// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order load/store request queue between execute and dmem.
// Accepts loads/stores from execute (other opcodes are consumed and dropped), buffers up to
// DEPTH of them, issues one per cycle onto dmem and presents dmem's registered response to
// writeback one cycle after issue, tagged with the destination register. A faulting
// (misaligned) response halts further issue until flush or rst.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_req_queue_if.slave: request, dmem, result, flush and halted signals
// Parameters: DEPTH (entries, power of 2, >= 2), TAG_W (destination tag width).
// Build option: define MEM_REQ_QUEUE_BYPASS_EN to let a request arriving at an empty queue
// issue in its accept cycle (1-cycle latency instead of 2).
module mem_req_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input logic            clk,
  input logic            rst,
  mem_req_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CountMax = CntW'(DEPTH);
  localparam logic [6:0]  OpLoad  = 7'b0000011;
  localparam logic [6:0]  OpStore = 7'b0100011;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [TAG_W-1:0] rd;
    logic             is_load;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              resp_valid_q;
  logic              resp_is_load_q;
  logic [TAG_W-1:0]  resp_rd_q;
  logic              halted_q;

  entry_t in_entry;
  entry_t issue_entry;
  logic   is_mem;
  logic   accept;
  logic   fault;
  logic   issue_ok;
  logic   pop;
  logic   bypass;
  logic   push;
  logic   issue;

  always_comb begin
    in_entry.instr   = bus.in_instr;
    in_entry.addr    = bus.in_addr;
    in_entry.data    = bus.in_data;
    in_entry.rd      = bus.in_rd;
    in_entry.is_load = (bus.in_instr[6:0] == OpLoad);
  end

  assign is_mem = (bus.in_instr[6:0] == OpLoad) || (bus.in_instr[6:0] == OpStore);

  // No pass-through when full: a same-cycle pop does not free a slot for this cycle.
  assign bus.in_ready = !rst && !bus.flush && (count_q < CountMax);
  assign accept       = bus.in_valid && bus.in_ready;

  // A faulting response blocks issue in its own cycle so nothing younger reaches dmem.
  assign fault    = bus.out_valid && bus.mem_err;
  assign issue_ok = !halted_q && !fault && !bus.flush && !rst;
  assign pop      = (count_q != '0) && issue_ok;

`ifdef MEM_REQ_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && accept && is_mem && issue_ok;
`else
  assign bypass = 1'b0;
`endif

  assign push        = accept && is_mem && !bypass;
  assign issue       = pop || bypass;
  assign issue_entry = pop ? fifo_q[rd_ptr_q] : in_entry;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_instr = Nop;
    bus.mem_addr  = '0;
    bus.mem_di    = '0;
    if (issue) begin
      bus.mem_en    = 1'b1;
      bus.mem_instr = issue_entry.instr;
      bus.mem_addr  = issue_entry.addr;
      bus.mem_di    = issue_entry.data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q      <= count_q + CntW'(push) - CntW'(pop);
      resp_valid_q <= issue;
      if (fault) begin
        halted_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rd_q      <= '0;
      resp_is_load_q <= 1'b0;
    end else if (issue) begin
      resp_rd_q      <= issue_entry.rd;
      resp_is_load_q <= issue_entry.is_load;
    end
  end

  // Result outputs are forced to their idle values while rst is high so an in-flight
  // response is discarded rather than leaking out during the reset cycle.
  assign bus.out_valid   = resp_valid_q && !rst;
  assign bus.out_is_load = resp_is_load_q && !rst;
  assign bus.out_rd      = rst ? '0 : resp_rd_q;
  assign bus.out_data    = bus.mem_dout;
  assign bus.out_err     = bus.out_valid && bus.mem_err;
  assign bus.halted      = halted_q;

endmodule
